instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
Inverse of the processor's opcode-to-control decoder. It accepts instruction fields (opcode, registers, immediate, target) over a valid/ready stream and packs them into 32-bit ECE550 instruction words. It writes the words sequentially into instruction memory through a registered write port. It is used by the test/boot loader to fill imem before the core is released from reset.

Parameters:
ADDR_W, 12, imem address width.
DEPTH, 4096, number of writable words. Must satisfy DEPTH <= 2**ADDR_W and DEPTH >= 2.

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that begins a load session at address 0.
in_valid  in  1  field beat valid.
in_ready  out  1  block can accept a beat this cycle.
in_opcode  in  5  instruction opcode.
in_rd  in  5  destination register.
in_rs  in  5  source register 1.
in_rt  in  5  source register 2.
in_shamt  in  5  shift amount.
in_aluop  in  5  ALU function code.
in_imm  in  17  immediate, two's complement.
in_target  in  27  jump target.
in_last  in  1  marks the final beat of the session.
imem_wren  out  1  imem write strobe.
imem_addr  out  ADDR_W  imem write address.
imem_data  out  32  encoded instruction word.
busy  out  1  high in LOAD.
done  out  1  high in DONE.
err_illegal  out  1  sticky: an unsupported opcode was encoded.
err_full  out  1  sticky: the session hit DEPTH before in_last.
word_count  out  ADDR_W+1  number of words written this session.

Behaviour:
- Reset values: in_ready=0, imem_wren=0, imem_addr=0, imem_data=0, busy=0, done=0, err_illegal=0, err_full=0, word_count=0. The FSM resets to IDLE.
- FSM has three states: IDLE, LOAD, DONE.
  - IDLE: start moves to LOAD.
  - LOAD: an accepted beat with in_last=1 moves to DONE. An accepted beat written to address DEPTH-1 with in_last=0 also moves to DONE and sets err_full.
  - DONE: start moves to LOAD.
- On IDLE or DONE -> LOAD: the write pointer, word_count, err_illegal and err_full all clear.
- start while in LOAD is ignored.
- in_ready = (state==LOAD). A beat is accepted when in_valid && in_ready.
- Latency: a beat accepted at edge N produces imem_wren=1, imem_addr=ptr and imem_data=word during cycle N+1.
  - The write pointer and word_count increment on each accepted beat.
  - imem_wren is 0 in any cycle that follows a non-accepted cycle.
- Back-to-back accepted beats write consecutive addresses with no bubble.
- Format is derived from in_opcode; fields not belonging to that format are ignored:
  - R (00000): [31:27]=op, [26:22]=rd, [21:17]=rs, [16:12]=rt, [11:7]=shamt, [6:2]=aluop, [1:0]=0.
  - I (00010 bne, 00101 addi, 00110 blt, 00111 sw, 01000 lw): op, rd, rs, then [16:0]=imm.
  - JI (00001 j, 00011 jal, 10101 setx, 10110 bex): op, then [26:0]=target.
  - JII (00100 jr): op, then [26:22]=rd, [21:0]=0.
- Any other opcode is encoded as 32'h0 (nop), still written at its address, and sets err_illegal.
- The word on which the pointer reaches DEPTH-1 is still written; the pointer never wraps.
- in_last on the DEPTH-1 beat counts as a normal finish, so err_full stays 0.
- Reset mid-session: returns to IDLE, and imem_wren is 0 in the cycle after reset. A partially written imem is not cleared.
- When start and reset are high in the same cycle, reset wins.

Decomposition:
- Shared package (processor-wide) holds:
  - Opcode constants (OP_RTYPE, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI, OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX).
  - The instruction-format enum {FMT_R, FMT_I, FMT_JI, FMT_JII}.
  - Field bit-position constants.
- The control decoder and this block both import that package.
- One combinational sub-module, instr_field_pack, maps opcode+fields to {word, illegal}. The top level holds the FSM, pointer and output registers.

Test Plan:
1. reset, start, beat op=00000 rd=1 rs=2 rt=3 shamt=0 aluop=0 last=1 -> next cycle imem_wren=1, addr=0, data=32'h00443000; then done=1, word_count=1.
2. Start, then back-to-back beats addi rd=5 rs=0 imm=17'h1FFFF; jal target=27'h64; jr rd=31 last=1 -> addr 0/1/2 carry 32'h2941FFFF, 32'h18000064, 32'h27C00000 on consecutive cycles with no bubble.
3. Beat opcode=01111 with all fields nonzero -> data=32'h0 written, err_illegal=1 and held until the next start.
4. DEPTH=4, 6 beats presented with no in_last -> exactly 4 writes (addr 0..3), err_full=1, done=1, in_ready=0 afterward.
5. Reset asserted two beats into a session, with in_valid still high -> imem_wren=0 the next cycle, busy=0, in_ready=0; a new start writes from addr 0.
6. start pulsed during LOAD, plus in_valid toggled as 1,0,1 -> start has no effect; two writes at consecutive addresses with one idle cycle between them.

Source files
------------

// File: rtl/instr_stream_encoder_pkg.sv
// Processor-wide ISA definitions: opcodes, instruction formats and field positions.
// Shared by the control decoder and the instruction stream encoder.
package instr_stream_encoder_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_JI, FMT_JII} fmt_e;

    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;

    typedef struct packed {
        fmt_e fmt;
        logic legal;
    } fmt_info_t;

    function automatic fmt_info_t fmt_of(input logic [4:0] op);
        fmt_info_t info;
        info.fmt   = FMT_R;
        info.legal = 1'b1;
        case (op)
            OP_RTYPE:                              info.fmt = FMT_R;
            OP_BNE, OP_ADDI, OP_BLT, OP_SW, OP_LW: info.fmt = FMT_I;
            OP_J, OP_JAL, OP_SETX, OP_BEX:         info.fmt = FMT_JI;
            OP_JR:                                 info.fmt = FMT_JII;
            default:                               info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: opcode plus instruction fields -> 32-bit instruction word.
// Unsupported opcodes produce a zero word (nop) and raise o_illegal.
module instr_field_pack
    import instr_stream_encoder_pkg::*;
(
    input  logic [4:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_shamt,
    input  logic [4:0]  i_aluop,
    input  logic [16:0] i_imm,
    input  logic [26:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    fmt_info_t w_info;

    assign w_info = fmt_of(i_opcode);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch.
        o_word    = 32'h0;
        o_illegal = ~w_info.legal;
        if (w_info.legal) begin
            o_word = 32'(i_opcode) << OPC_LSB;
            case (w_info.fmt)
                FMT_R:   o_word = o_word | (32'(i_rd) << RD_LSB) | (32'(i_rs) << RS_LSB)
                                         | (32'(i_rt) << RT_LSB) | (32'(i_shamt) << SHAMT_LSB)
                                         | (32'(i_aluop) << ALUOP_LSB);
                FMT_I:   o_word = o_word | (32'(i_rd) << RD_LSB) | (32'(i_rs) << RS_LSB)
                                         | 32'(i_imm);
                FMT_JI:  o_word = o_word | 32'(i_target);
                FMT_JII: o_word = o_word | (32'(i_rd) << RD_LSB);
                default: o_word = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Loader-side encoder: accepts instruction-field beats and writes packed words
// sequentially into imem through a registered write port, one cycle after acceptance.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    input  logic              in_last,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_in_ready;
    logic              r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err_illegal;
    logic              r_err_full;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_accept;
    logic              w_at_end;

    instr_field_pack u_pack (
        .i_opcode  (in_opcode),
        .i_rd      (in_rd),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_shamt   (in_shamt),
        .i_aluop   (in_aluop),
        .i_imm     (in_imm),
        .i_target  (in_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_at_end = (r_ptr == LAST_ADDR);

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_word_count  <= '0;
            r_in_ready    <= 1'b0;
            r_wren        <= 1'b0;
            r_addr        <= '0;
            r_data        <= 32'h0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_full    <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_LOAD;
                        r_ptr         <= '0;
                        r_word_count  <= '0;
                        r_err_illegal <= 1'b0;
                        r_err_full    <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_wren        <= 1'b1;
                        r_addr        <= r_ptr;
                        r_data        <= w_word;
                        r_word_count  <= r_word_count + (ADDR_W + 1)'(1);
                        r_err_illegal <= r_err_illegal | w_illegal;
                        // The pointer saturates at the last address; the session ends there anyway.
                        if (!w_at_end) begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                        if (in_last || w_at_end) begin
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_err_full <= !in_last;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign imem_wren   = r_wren;
    assign imem_addr   = r_addr;
    assign imem_data   = r_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_illegal = r_err_illegal;
    assign err_full    = r_err_full;
    assign word_count  = r_word_count;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: expected imem writes are queued as beats
// are accepted and compared as the write port fires.
module tb_instr_stream_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  sh;
        logic [4:0]  alu;
        logic [16:0] imm;
        logic [26:0] tgt;
    } beat_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop;
    logic [16:0]       in_imm;
    logic [26:0]       in_target;
    logic              in_last;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              busy, done, err_illegal, err_full;
    logic [ADDR_W:0]   word_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_ptr  = 0;
    wr_t exp_q[$];
    int  wr_cycles[$];

    instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_shamt(in_shamt), .in_aluop(in_aluop), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last),
        .imem_wren(imem_wren), .imem_addr(imem_addr), .imem_data(imem_data),
        .busy(busy), .done(done), .err_illegal(err_illegal), .err_full(err_full),
        .word_count(word_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference encoding built by field concatenation.
    function automatic logic [31:0] model_word(input beat_t b);
        case (b.op)
            5'b00000: return {b.op, b.rd, b.rs, b.rt, b.sh, b.alu, 2'b00};
            5'b00010, 5'b00101, 5'b00110, 5'b00111, 5'b01000:
                      return {b.op, b.rd, b.rs, b.imm};
            5'b00001, 5'b00011, 5'b10101, 5'b10110:
                      return {b.op, b.tgt};
            5'b00100: return {b.op, b.rd, 22'h0};
            default:  return 32'h0;
        endcase
    endfunction

    always @(negedge clock) begin
        if (imem_wren) begin
            wr_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("spurious_wr", 64'(imem_wren), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e.addr));
                check("wr_data", 64'(imem_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_fields(input beat_t b, input logic last);
        in_opcode = b.op; in_rd = b.rd; in_rs = b.rs; in_rt = b.rt;
        in_shamt = b.sh; in_aluop = b.alu; in_imm = b.imm; in_target = b.tgt;
        in_last = last;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_ptr = 0;
        wr_cycles.delete();
    endtask

    // Presents one beat, waits (bounded) for in_ready, and queues the expected write.
    task automatic send_beat(input beat_t b, input logic last);
        int n;
        wr_t e;
        in_valid = 1'b1;
        drive_fields(b, last);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            e.addr = ADDR_W'(exp_ptr);
            e.data = model_word(b);
            exp_q.push_back(e);
            if (exp_ptr < DEPTH - 1) exp_ptr++;
            tick();
        end
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        tick();
        tick();
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    function automatic beat_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [16:0] imm, input logic [26:0] tgt);
        beat_t b;
        b.op = op; b.rd = rd; b.rs = rs; b.rt = rt; b.sh = 5'd0; b.alu = 5'd0;
        b.imm = imm; b.tgt = tgt;
        return b;
    endfunction

    initial begin
        beat_t b;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        drive_fields(mk(5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0), 1'b0);
        repeat (3) tick();
        // Reset state, with start high alongside reset (reset must win).
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wren", 64'(imem_wren), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_data", 64'(imem_data), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_errs", 64'({err_illegal, err_full}), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_not_ready", 64'(in_ready), 64'd0);

        // 1: single R-type beat.
        do_start();
        check("t1_busy", 64'(busy), 64'd1);
        send_beat(mk(5'b00000, 5'd1, 5'd2, 5'd3, 17'd0, 27'd0), 1'b1);
        check("t1_model", 64'(model_word(mk(5'b00000, 5'd1, 5'd2, 5'd3, 17'd0, 27'd0))), 64'h00443000);
        drain("t1_drain");
        check("t1_done", 64'({busy, done}), 64'b01);
        check("t1_count", 64'(word_count), 64'd1);

        // 2: back-to-back addi / jal / jr.
        do_start();
        send_beat(mk(5'b00101, 5'd5, 5'd0, 5'd0, 17'h1FFFF, 27'd0), 1'b0);
        send_beat(mk(5'b00011, 5'd0, 5'd0, 5'd0, 17'd0, 27'h64), 1'b0);
        send_beat(mk(5'b00100, 5'd31, 5'd0, 5'd0, 17'd0, 27'd0), 1'b1);
        drain("t2_drain");
        check("t2_nwr", 64'(wr_cycles.size()), 64'd3);
        if (wr_cycles.size() == 3)
            check("t2_no_bubble", 64'(wr_cycles[2] - wr_cycles[0]), 64'd2);
        check("t2_count", 64'(word_count), 64'd3);

        // 3: illegal opcode writes a nop and sets sticky err_illegal.
        do_start();
        b = mk(5'b01111, 5'd7, 5'd9, 5'd11, 17'h1234, 27'h55555);
        b.sh = 5'd3; b.alu = 5'd6;
        send_beat(b, 1'b1);
        drain("t3_drain");
        check("t3_illegal", 64'(err_illegal), 64'd1);
        repeat (4) tick();
        check("t3_illegal_held", 64'(err_illegal), 64'd1);
        do_start();
        check("t3_illegal_clr", 64'(err_illegal), 64'd0);
        send_beat(mk(5'b01000, 5'd4, 5'd8, 5'd0, 17'h00ABC, 27'd0), 1'b1);
        drain("t3b_drain");
        check("t3_illegal_still0", 64'(err_illegal), 64'd0);

        // 4: six beats without in_last into a DEPTH=4 memory.
        do_start();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = mk(5'b00101, 5'(i), 5'd1, 5'd0, 17'(i + 100), 27'd0);
            drive_fields(b, 1'b0);
            if (i < DEPTH) begin
                wr_t e;
                e.addr = ADDR_W'(i);
                e.data = model_word(b);
                exp_q.push_back(e);
            end
            tick();
        end
        drain("t4_drain");
        check("t4_nwr", 64'(wr_cycles.size()), 64'd4);
        check("t4_err_full", 64'(err_full), 64'd1);
        check("t4_done", 64'(done), 64'd1);
        check("t4_ready", 64'(in_ready), 64'd0);
        check("t4_count", 64'(word_count), 64'd4);

        // 4b: in_last on the DEPTH-1 beat is a normal finish.
        do_start();
        check("t4b_full_clr", 64'(err_full), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            send_beat(mk(5'b00001, 5'd0, 5'd0, 5'd0, 17'd0, 27'(i * 3 + 1)), i == DEPTH - 1);
        drain("t4b_drain");
        check("t4b_err_full", 64'(err_full), 64'd0);
        check("t4b_done", 64'(done), 64'd1);
        check("t4b_count", 64'(word_count), 64'd4);

        // 5: reset two beats into a session with in_valid still high.
        do_start();
        send_beat(mk(5'b00010, 5'd2, 5'd3, 5'd0, 17'h00010, 27'd0), 1'b0);
        send_beat(mk(5'b00110, 5'd6, 5'd7, 5'd0, 17'h1FFF0, 27'd0), 1'b0);
        drive_fields(mk(5'b00111, 5'd9, 5'd1, 5'd0, 17'h00001, 27'd0), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_wren", 64'(imem_wren), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_ready", 64'(in_ready), 64'd0);
        drain("t5_drain");
        do_start();
        send_beat(mk(5'b10101, 5'd0, 5'd0, 5'd0, 17'd0, 27'h7FFFFFF), 1'b1);
        drain("t5b_drain");

        // 6: start during LOAD is ignored; in_valid toggles 1,0,1.
        do_start();
        send_beat(mk(5'b10110, 5'd0, 5'd0, 5'd0, 17'd0, 27'h0ABCDEF), 1'b0);
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_busy", 64'(busy), 64'd1);
        send_beat(mk(5'b00000, 5'd31, 5'd30, 5'd29, 17'd0, 27'd0), 1'b1);
        drain("t6_drain");
        check("t6_nwr", 64'(wr_cycles.size()), 64'd2);
        if (wr_cycles.size() == 2)
            check("t6_gap", 64'(wr_cycles[1] - wr_cycles[0]), 64'd2);
        check("t6_count", 64'(word_count), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
